kme_fifo_rr_arb: RTL

- Shares one cr_kme_fifo-style write port (DATA_SIZE-wide, depth FIFO_DEPTH) among NUM_REQ requesters.
- Round-robin arbitration with packet locking.
- Credit-based flow control, so the FIFO is never written while full; the output write is registered.
- Sits directly upstream of the FIFO in the KME datapath; the FIFO's pop strobe returns credits.

---
 rtl/kme_fifo_rr_arb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/kme_fifo_rr_arb.sv
// Round-robin, packet-locking arbiter that shares one credit-managed FIFO write port among NUM_REQ requesters.
// Optional protocol/credit checking is built only when KME_FIFO_ARB_CHECK_EN is defined.
module kme_fifo_rr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_SIZE  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [DATA_SIZE-1:0]           fifo_in,
  output logic                           fifo_in_valid,
  input  logic                           fifo_pop,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           locked,
  output logic                           credit_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]           state;
  logic [IW-1:0]        rr_ptr;
  logic [CW-1:0]        credits;

  logic                 has_credit;
  logic                 win_vld;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        acc_idx;
  logic                 accept;
  logic                 acc_last;
  logic [DATA_SIZE-1:0] acc_data;

  // Index k positions after base, wrapped modulo NUM_REQ.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // A pop at full credit is a downstream protocol error; the count saturates rather than wrapping.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] c, input logic acc,
                                                input logic pop);
    logic [CW-1:0] n;
    n = c;
    if (acc && !pop) n = c - 1'b1;
    else if (!acc && pop && (c != CRED_MAX)) n = c + 1'b1;
    return n;
  endfunction

  assign has_credit = (credits != '0);
  assign locked     = (state == LOCKED);

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(rr_ptr, k)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(rr_ptr, k);
      end
    end
  end

  // Acks are forced low while reset is asserted so every output reads 0 during reset.
  always_comb begin
    acc_idx  = (state == LOCKED) ? grant_id : win_idx;
    accept   = rst_n && has_credit && ((state == IDLE) ? win_vld : req_valid[grant_id]);
    acc_last = req_last[acc_idx];
    acc_data = '0;
    req_ack  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_idx == IW'(i)) begin
        acc_data   = req_data[i*DATA_SIZE +: DATA_SIZE];
        req_ack[i] = accept;
      end
    end
  end

  // ---- stage p0 -> registered FIFO write, credit and arbitration state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      credits       <= CRED_MAX;
      fifo_in_valid <= 1'b0;
      fifo_in       <= '0;
    end else begin
      fifo_in_valid <= accept;
      credits       <= credit_next(credits, accept, fifo_pop);
      if (accept) begin
        fifo_in <= acc_data;
        state   <= acc_last ? IDLE : LOCKED;
      end
      if (accept && (state == IDLE)) begin
        grant_id <= win_idx;
        rr_ptr   <= rr_idx(win_idx, 1);
      end
    end
  end

`ifdef KME_FIFO_ARB_CHECK_EN
  logic [NUM_REQ-1:0]           pend_q;
  logic [NUM_REQ*DATA_SIZE-1:0] data_q;
  logic                         err_q;
  logic                         viol_pop;
  logic                         viol_hold;

  // A requester left un-acked last cycle must keep valid high and data unchanged.
  always_comb begin
    viol_pop  = fifo_pop && (credits == CRED_MAX);
    viol_hold = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend_q[i] && (!req_valid[i] ||
          (req_data[i*DATA_SIZE +: DATA_SIZE] != data_q[i*DATA_SIZE +: DATA_SIZE])))
        viol_hold = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= req_valid & ~req_ack;
      err_q  <= err_q | viol_pop | viol_hold;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= req_data;
  end

  assign credit_err = err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && (viol_pop || viol_hold))
      $display("kme_fifo_rr_arb: protocol error (pop_at_full=%0b hold_violation=%0b) at %0t",
               viol_pop, viol_hold, $time);
  end
`endif
`else
  assign credit_err = 1'b0;
`endif

endmodule
